serial2mem: RTL and testbench
=============================

Name: serial2mem

Overview:
- Host-side inverse of the sniffer's frame serializer.
- Consumes the UART receive byte stream, hunts for the two-byte sync preamble 0xFF 0xFF, then captures exactly 8 payload bytes into one 8-byte slot of a frame buffer through a simple write port.
- Pulses write_done per completed frame; aborts partial frames on inter-byte timeout.
- Used for loopback verification and for replaying captured LPC frames into the on-chip buffer.

Parameters:
AW, 8, buffer address width; slot index is AW-3 bits, byte index 3 bits.
TIMEOUT, 1024, max clock cycles between received bytes inside a frame before abort (>=2).

Ports:
clock  input  1  system clock, all logic on posedge.
reset  input  1  asynchronous, active-high reset.
uart_data  input  8  received byte, valid only when uart_valid=1.
uart_valid  input  1  one-cycle strobe per received byte.
target_addr  input  AW-3  slot to write; sampled when sync completes, held internally for the frame.
write_full  input  1  buffer cannot accept a frame; sampled when sync completes.
write_enable  output  1  one-cycle write strobe.
write_addr  output  AW  {latched target_addr, byte index[2:0]}.
write_data  output  8  byte to write.
write_done  output  1  one-cycle pulse, frame committed.
frame_drop  output  1  one-cycle pulse, frame discarded because write_full.
frame_error  output  1  one-cycle pulse, frame aborted by timeout.

Behaviour:
- Reset (async, active-high): state=HUNT, idx=0, timer=0. All outputs 0, including write_addr and write_data.
- Only cycles with uart_valid=1 consume a byte. uart_data is ignored otherwise.
- HUNT: byte==0xFF -> SYNC1; other bytes stay in HUNT with no output.
- SYNC1: byte==0xFF -> latch target_addr, idx=0. Go to DROP if write_full=1, else PAYLOAD. Any other byte -> HUNT, no error.
- PAYLOAD: each byte, any value including 0xFF, produces on the next cycle:
  - write_enable=1 for exactly 1 cycle
  - write_data=byte
  - write_addr={slot,idx}
  - then idx increments.
  - After byte idx=7: write_done=1 on the cycle after its write_enable; state -> HUNT.
- DROP: consumes 8 bytes with no writes. frame_drop pulses on the cycle after the 8th byte; state -> HUNT.
- Timeout: timer clears on every uart_valid and counts otherwise while in SYNC1/PAYLOAD/DROP.
  - When timer reaches TIMEOUT-1 with no byte: state -> HUNT, idx=0.
  - frame_error pulses next cycle, but only if in PAYLOAD or DROP. SYNC1 timeout returns to HUNT silently.
  - Bytes already written stay in the buffer; write_done is not issued.
- Simultaneous uart_valid and timer expiry: byte wins, no timeout.
- write_full is ignored after sync completes. A frame in PAYLOAD always finishes.
- A byte arriving on the cycle write_done/frame_drop pulses is processed in HUNT. Back-to-back frames need no gap.
- Reset mid-frame: immediate return to HUNT. No write_done/frame_error is generated for the partial frame.
- Latency: uart_valid of payload byte n -> write_enable exactly 1 cycle later. 8th byte -> write_done 2 cycles later.
- Timer width: $clog2(TIMEOUT); it never wraps because it is cleared at expiry.

Decomposition:
- Shared package (lpc_frame_pkg):
  - SYNC_BYTE=8'hFF, SYNC_LEN=2, FRAME_LEN=8
  - state enum {HUNT, SYNC1, PAYLOAD, DROP}
  - mem2serial is also to use SYNC_BYTE/FRAME_LEN from this package.
- One sub-module: byte_timeout (clear, enable, expired pulse, TIMEOUT parameter). It is reusable by the UART receiver.

Test Plan:
- Clean frame: target_addr=5, bytes FF FF 01 02 .. 08 -> 8 writes at addresses 0x28..0x2F with data 01..08, then write_done 1 cycle after the last write.
- Noise plus false sync: 12 FF 34 FF FF AA x8 -> no writes until the second consecutive FF, then 8 writes of AA, one write_done, no frame_error.
- Payload containing FF: FF FF FF FF FF FF FF FF FF FF -> 8 writes of FF, write_done, then HUNT. A following FF FF 00x8 gives a second complete frame.
- Timeout: TIMEOUT=16, send FF FF 11 22 33 then idle 20 cycles -> 3 writes, frame_error exactly once at cycle 16 after byte 33, no write_done. Next full frame succeeds.
- Buffer full: write_full=1 during the second FF, then deasserted, 8 bytes follow -> zero write_enable, frame_drop pulse after the 8th byte.
- Reset mid-frame: assert reset after 4 payload bytes -> all outputs 0 asynchronously. After release, the next FF FF + 8 bytes writes from byte index 0.

Source files
------------

// File: rtl/lpc_frame_pkg.sv
// Shared LPC frame format constants and the serial-to-memory FSM state type.
// Used by serial2mem and mem2serial.
package lpc_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam int         SYNC_LEN  = 2;
    localparam int         FRAME_LEN = 8;

    typedef enum logic [1:0] {
        HUNT,
        SYNC1,
        PAYLOAD,
        DROP
    } state_t;

    function automatic logic is_sync(input logic [7:0] b);
        return b == SYNC_BYTE;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: counts idle cycles while enabled, pulses on expiry.
// Reusable by the UART receiver.
module byte_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int             TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_timer;

    // A byte on the expiry cycle wins, so clear masks the pulse.
    assign o_expired = i_enable && !i_clear && (r_timer == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (i_clear || !i_enable || o_expired) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: rtl/serial2mem.sv
// Sync-hunting UART byte stream to frame buffer writer.
// Captures 8-byte payloads after an FF FF preamble into one buffer slot.
module serial2mem
    import lpc_frame_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    uart_data,
    input  logic          uart_valid,
    input  logic [AW-4:0] target_addr,
    input  logic          write_full,
    output logic          write_enable,
    output logic [AW-1:0] write_addr,
    output logic [7:0]    write_data,
    output logic          write_done,
    output logic          frame_drop,
    output logic          frame_error
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [AW-4:0] r_slot;
    logic          r_last;
    logic          w_expired;
    logic          w_active;

    assign w_active = (r_state != HUNT);

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (uart_valid),
        .i_enable  (w_active),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_idx        <= '0;
            r_slot       <= '0;
            r_last       <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_done   <= 1'b0;
            frame_drop   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            frame_drop   <= 1'b0;
            frame_error  <= 1'b0;
            write_done   <= r_last;
            r_last       <= 1'b0;
            if (uart_valid) begin
                unique case (r_state)
                    HUNT: begin
                        if (is_sync(uart_data)) r_state <= SYNC1;
                    end
                    SYNC1: begin
                        if (is_sync(uart_data)) begin
                            r_slot  <= target_addr;
                            r_idx   <= '0;
                            r_state <= write_full ? DROP : PAYLOAD;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    PAYLOAD: begin
                        write_enable <= 1'b1;
                        write_data   <= uart_data;
                        write_addr   <= {r_slot, r_idx};
                        r_idx        <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_last  <= 1'b1;
                            r_state <= HUNT;
                        end
                    end
                    DROP: begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            frame_drop <= 1'b1;
                            r_state    <= HUNT;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end else if (w_expired) begin
                // A timeout while still in SYNC1 is not a frame error.
                frame_error <= (r_state == PAYLOAD) || (r_state == DROP);
                r_state     <= HUNT;
                r_idx       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial2mem.sv
// Self-checking bench for serial2mem: directed scenarios plus random traffic
// compared every cycle against an arrival-time based frame model.
module tb_serial2mem;

    localparam int TMO  = 16;
    localparam int MAXC = 8192;

    logic       clock = 0;
    logic       reset = 0;
    logic [7:0] uart_data = 0;
    logic       uart_valid = 0;
    logic [4:0] target_addr = 0;
    logic       write_full = 0;
    logic       write_enable;
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic       write_done;
    logic       frame_drop;
    logic       frame_error;

    serial2mem #(
        .AW      (8),
        .TIMEOUT (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_data    (uart_data),
        .uart_valid   (uart_valid),
        .target_addr  (target_addr),
        .write_full   (write_full),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_done   (write_done),
        .frame_drop   (frame_drop),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected outputs, indexed by the clock edge after which they are visible.
    bit       exp_we   [MAXC];
    bit       exp_done [MAXC];
    bit       exp_drop [MAXC];
    bit       exp_err  [MAXC];
    bit [7:0] exp_addr [MAXC];
    bit [7:0] exp_data [MAXC];

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Model: mode 0 hunting, 1 one FF seen, 2 writing, 3 dropping.
    int       m_mode = 0;
    int       m_cnt  = 0;
    int       m_last = 0;
    bit [4:0] m_slot = 0;

    task automatic model_step(input int e, input logic v, input logic [7:0] b,
                              input logic full, input logic [4:0] tgt);
        if (v) begin
            m_last = e;
            if (m_mode == 0) begin
                if (b == 8'hFF) m_mode = 1;
            end else if (m_mode == 1) begin
                if (b == 8'hFF) begin
                    m_slot = tgt;
                    m_cnt  = 0;
                    m_mode = full ? 3 : 2;
                end else begin
                    m_mode = 0;
                end
            end else if (m_mode == 2) begin
                exp_we[e]   = 1;
                exp_addr[e] = m_slot * 8 + m_cnt;
                exp_data[e] = b;
                m_cnt++;
                if (m_cnt == 8) begin
                    exp_done[e+1] = 1;
                    m_mode = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 8) begin
                    exp_drop[e] = 1;
                    m_mode = 0;
                end
            end
        end else if (m_mode != 0 && e - m_last == TMO) begin
            if (m_mode >= 2) exp_err[e] = 1;
            m_mode = 0;
        end
    endtask

    int       o_we, o_done, o_drop, o_err;
    int       o_done_cyc, o_drop_cyc, o_err_cyc;
    bit [7:0] o_addr[$];
    bit [7:0] o_data[$];

    task automatic clr_obs();
        o_we = 0; o_done = 0; o_drop = 0; o_err = 0;
        o_done_cyc = -1; o_drop_cyc = -1; o_err_cyc = -1;
        o_addr.delete();
        o_data.delete();
    endtask

    always @(negedge clock) begin
        if (cyc < MAXC) begin
            chk("write_enable", write_enable, exp_we[cyc]);
            chk("write_done", write_done, exp_done[cyc]);
            chk("frame_drop", frame_drop, exp_drop[cyc]);
            chk("frame_error", frame_error, exp_err[cyc]);
            if (exp_we[cyc]) begin
                chk("write_addr", write_addr, exp_addr[cyc]);
                chk("write_data", write_data, exp_data[cyc]);
            end
            if (reset) begin
                chk("reset_addr", write_addr, 0);
                chk("reset_data", write_data, 0);
            end
            if (write_enable === 1'b1) begin
                o_we++;
                o_addr.push_back(write_addr);
                o_data.push_back(write_data);
            end
            if (write_done === 1'b1) begin o_done++; o_done_cyc = cyc; end
            if (frame_drop === 1'b1) begin o_drop++; o_drop_cyc = cyc; end
            if (frame_error === 1'b1) begin o_err++; o_err_cyc = cyc; end
        end
    end

    logic [4:0] cur_tgt  = 5;
    logic       cur_full = 0;
    int         last_e   = 0;

    task automatic step(input logic v, input logic [7:0] b);
        @(posedge clock);
        #1;
        uart_valid  = v;
        uart_data   = v ? b : 8'($urandom);
        write_full  = cur_full;
        target_addr = cur_tgt;
        model_step(cyc + 1, v, b, cur_full, cur_tgt);
        last_e = cyc + 1;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    int e33;
    int e8;
    int r;
    int idle_left;

    initial begin
        clr_obs();
        #1 reset = 1;
        @(negedge clock);
        chk("rst_we", write_enable, 0);
        chk("rst_done", write_done, 0);
        chk("rst_err", frame_error, 0);
        @(posedge clock);
        #1 reset = 0;
        idle(2);

        // Clean frame into slot 5
        clr_obs();
        cur_tgt = 5;
        send(8'hFF); send(8'hFF);
        for (int i = 1; i <= 8; i++) send(8'(i));
        e8 = last_e;
        idle(4);
        chk("clean_writes", o_we, 8);
        chk("clean_addr0", o_addr[0], 8'h28);
        chk("clean_data0", o_data[0], 8'h01);
        chk("clean_addr7", o_addr[7], 8'h2F);
        chk("clean_data7", o_data[7], 8'h08);
        chk("clean_done", o_done, 1);
        chk("clean_done_lat", o_done_cyc - e8, 1);

        // Noise and a false sync
        clr_obs();
        cur_tgt = 2;
        send(8'h12); send(8'hFF); send(8'h34); send(8'hFF); send(8'hFF);
        for (int i = 0; i < 8; i++) send(8'hAA);
        idle(4);
        chk("noise_writes", o_we, 8);
        chk("noise_data7", o_data[7], 8'hAA);
        chk("noise_addr0", o_addr[0], 8'h10);
        chk("noise_done", o_done, 1);
        chk("noise_err", o_err, 0);

        // FF payload then back-to-back frame
        clr_obs();
        cur_tgt = 1;
        for (int i = 0; i < 10; i++) send(8'hFF);
        send(8'hFF); send(8'hFF);
        for (int i = 0; i < 8; i++) send(8'h00);
        idle(4);
        chk("ffpay_writes", o_we, 16);
        chk("ffpay_data0", o_data[0], 8'hFF);
        chk("ffpay_data8", o_data[8], 8'h00);
        chk("ffpay_done", o_done, 2);

        // Timeout mid-payload
        clr_obs();
        cur_tgt = 7;
        send(8'hFF); send(8'hFF); send(8'h11); send(8'h22); send(8'h33);
        e33 = last_e;
        idle(20);
        chk("tmo_writes", o_we, 3);
        chk("tmo_err", o_err, 1);
        chk("tmo_err_cyc", o_err_cyc - e33, 16);
        chk("tmo_done", o_done, 0);
        clr_obs();
        send(8'hFF); send(8'hFF);
        for (int i = 0; i < 8; i++) send(8'h5A);
        idle(4);
        chk("tmo_next_done", o_done, 1);
        chk("tmo_next_addr0", o_addr[0], 8'h38);

        // Buffer full at sync
        clr_obs();
        send(8'hFF);
        cur_full = 1;
        send(8'hFF);
        cur_full = 0;
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i));
        e8 = last_e;
        idle(4);
        chk("full_writes", o_we, 0);
        chk("full_drop", o_drop, 1);
        chk("full_drop_cyc", o_drop_cyc - e8, 0);

        // Reset in the middle of a payload
        clr_obs();
        cur_tgt = 4;
        send(8'hFF); send(8'hFF);
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
        @(posedge clock);
        #1;
        chk("pre_reset_we", write_enable, 1);
        uart_valid = 0;
        reset = 1;
        m_mode = 0;
        for (int k = 0; k < 4; k++) begin
            exp_we[cyc+k] = 0; exp_done[cyc+k] = 0;
            exp_drop[cyc+k] = 0; exp_err[cyc+k] = 0;
        end
        #1;
        chk("async_we", write_enable, 0);
        chk("async_addr", write_addr, 0);
        chk("async_data", write_data, 0);
        repeat (3) @(posedge clock);
        #1 reset = 0;
        clr_obs();
        cur_tgt = 3;
        send(8'hFF); send(8'hFF);
        for (int i = 0; i < 8; i++) send(8'(8'hD0 + i));
        idle(30);
        chk("rst_next_writes", o_we, 8);
        chk("rst_next_addr0", o_addr[0], 8'h18);
        chk("rst_next_done", o_done, 1);
        chk("rst_next_err", o_err, 0);

        // Random traffic checked only by the per-cycle model
        idle_left = 0;
        for (int i = 0; i < 2000; i++) begin
            cur_full = ($urandom_range(0, 3) == 0);
            cur_tgt  = 5'($urandom);
            if (idle_left > 0) begin
                idle_left--;
                step(1'b0, 8'h00);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3) idle_left = $urandom_range(10, 25);
                if (r < 60)
                    send(($urandom_range(0, 9) < 4) ? 8'hFF : 8'($urandom));
                else
                    step(1'b0, 8'h00);
            end
        end
        cur_full = 0;
        idle(30);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
